// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and state types plus the signed-overflow rule shared by alu_pipe
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_INC = 4'd6,
    OP_DEC = 4'd7,
    OP_MUL = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10,
    OP_SAR = 4'd11
  } op_e;

  // Highest defined opcode; anything above it is reported through err.
  localparam op_e OP_LAST = OP_SAR;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative unsigned shift-add multiplier, one partial product per cycle
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // product carries the final partial sum combinationally so the owner can
  // register it on the same edge the count runs out.
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CW'(1));
  assign product = acc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= CW'(WIDTH);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result/flags and a sequential multiplier
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               overflow,
  output logic               zero,
  output logic               sign,
  output logic               err
);

  localparam int SW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               carry_q, carry_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;
  logic               sign_q, sign_d;
  logic               err_q, err_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               mul_load, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]     sum_w, diff_w, inc_w, dec_w;
  logic [SW-1:0]      shamt;
  logic [WIDTH-1:0]   lo;
  logic               cy, ov, er, is_mul;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign inc_w  = {1'b0, a} + (WIDTH+1)'(1);
  assign dec_w  = {1'b0, a} - (WIDTH+1)'(1);
  assign shamt  = b[SW-1:0];

  always_comb begin
    lo     = '0;
    cy     = 1'b0;
    ov     = 1'b0;
    is_mul = 1'b0;
    er     = (op > OP_LAST);
    case (op)
      OP_ADD: begin
        lo = sum_w[WIDTH-1:0];
        cy = sum_w[WIDTH];
        ov = signed_ovf(a[WIDTH-1], b[WIDTH-1], sum_w[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        lo = diff_w[WIDTH-1:0];
        cy = diff_w[WIDTH];
        ov = signed_ovf(a[WIDTH-1], b[WIDTH-1], diff_w[WIDTH-1], 1'b1);
      end
      OP_AND: lo = a & b;
      OP_OR:  lo = a | b;
      OP_XOR: lo = a ^ b;
      OP_NOT: lo = ~a;
      // INC/DEC treat the implicit operand 1 as b, whose MSB is 0.
      OP_INC: begin
        lo = inc_w[WIDTH-1:0];
        cy = inc_w[WIDTH];
        ov = signed_ovf(a[WIDTH-1], 1'b0, inc_w[WIDTH-1], 1'b0);
      end
      OP_DEC: begin
        lo = dec_w[WIDTH-1:0];
        cy = dec_w[WIDTH];
        ov = signed_ovf(a[WIDTH-1], 1'b0, dec_w[WIDTH-1], 1'b1);
      end
      OP_MUL: is_mul = 1'b1;
      OP_SHL: lo = a << shamt;
      OP_SHR: lo = a >> shamt;
      OP_SAR: lo = WIDTH'($signed(a) >>> shamt);
      default: lo = '0;
    endcase
  end

  assign in_ready = (state_q == IDLE) && !mul_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    sign_d      = sign_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    mul_load    = 1'b0;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d     = BUSY;
          mul_load    = 1'b1;
          out_valid_d = 1'b0;
        end else if (accept) begin
          result_d    = {{WIDTH{1'b0}}, lo};
          carry_d     = cy;
          overflow_d  = ov;
          zero_d      = (lo == '0);
          sign_d      = lo[WIDTH-1];
          err_d       = er;
          out_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d     = IDLE;
          result_d    = mul_product;
          carry_d     = 1'b0;
          overflow_d  = 1'b0;
          zero_d      = (mul_product == '0);
          sign_d      = mul_product[2*WIDTH-1];
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed checks of alu_pipe at WIDTH 8 and 16
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        v_in_valid = 1'b0, v_in_ready, v_out_valid, v_out_ready = 1'b1;
  logic [7:0]  v_a = '0, v_b = '0;
  logic [3:0]  v_op = '0;
  logic [15:0] v_result;
  logic        v_carry, v_overflow, v_zero, v_sign, v_err;
  logic [4:0]  v_flags;

  logic        w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b1;
  logic [15:0] w_a = '0, w_b = '0;
  logic [3:0]  w_op = '0;
  logic [31:0] w_result;
  logic        w_carry, w_overflow, w_zero, w_sign, w_err;
  logic [4:0]  w_flags;

  // flag vectors are {carry, overflow, zero, sign, err}
  assign v_flags = {v_carry, v_overflow, v_zero, v_sign, v_err};
  assign w_flags = {w_carry, w_overflow, w_zero, w_sign, w_err};

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v_in_valid), .in_ready(v_in_ready),
    .a(v_a), .b(v_b), .op(v_op), .out_valid(v_out_valid), .out_ready(v_out_ready),
    .result(v_result), .carry(v_carry), .overflow(v_overflow), .zero(v_zero),
    .sign(v_sign), .err(v_err)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_result), .carry(w_carry), .overflow(w_overflow), .zero(w_zero),
    .sign(w_sign), .err(w_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    v_in_valid = 1'b1; v_op = op; v_a = a; v_b = b;
    @(posedge clk); #1;
    v_in_valid = 1'b0;
  endtask

  task automatic wait_mul8(input string tag, input int exp_cyc);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    chk({tag, "_ready0"}, 64'(v_in_ready), 64'(0));
    while (!v_out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!v_out_valid && v_in_ready) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_cyc));
    chk({tag, "_busy_ready"}, 64'(busy_ok), 64'(1));
  endtask

  logic [3:0]  bb_op  [4] = '{4'd2, 4'd3, 4'd9, 4'd11};
  logic [7:0]  bb_a   [4] = '{8'hCC, 8'hC0, 8'h81, 8'h80};
  logic [7:0]  bb_b   [4] = '{8'hAA, 8'h0C, 8'h01, 8'h01};
  logic [15:0] bb_res [4] = '{16'h0088, 16'h00CC, 16'h0002, 16'h00C0};
  logic [4:0]  bb_flg [4] = '{5'b00010, 5'b00010, 5'b00000, 5'b00010};

  initial begin
    int hits;
    int n;

    repeat (3) @(posedge clk);
    #1;
    chk("in_reset_ready", 64'(v_in_ready), 64'(1));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_result", 64'(v_result), 64'(0));
    chk("reset_ctl", 64'({v_out_valid, v_flags, v_in_ready}), 64'(7'b0000001));

    // abort a multiply with reset four cycles in
    send8(4'd8, 8'h0F, 8'h03);
    chk("abort_ready0", 64'(v_in_ready), 64'(0));
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("abort_rst_ready", 64'({v_out_valid, v_in_ready}), 64'(2'b01));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (v_out_valid) hits++;
    end
    chk("abort_no_valid", 64'(hits), 64'(0));
    chk("abort_ready1", 64'(v_in_ready), 64'(1));
    chk("abort_result", 64'({v_result, v_flags}), 64'(0));

    send8(4'd0, 8'hFF, 8'h01);
    chk("add_ff_res", 64'({v_out_valid, v_result}), 64'({1'b1, 16'h0000}));
    chk("add_ff_flg", 64'(v_flags), 64'(5'b10100));
    send8(4'd0, 8'h7F, 8'h01);
    chk("add_7f_res", 64'(v_result), 64'(16'h0080));
    chk("add_7f_flg", 64'(v_flags), 64'(5'b01010));
    send8(4'd1, 8'h00, 8'h01);
    chk("sub_res", 64'(v_result), 64'(16'h00FF));
    chk("sub_flg", 64'(v_flags), 64'(5'b10010));
    send8(4'd7, 8'h80, 8'h00);
    chk("dec_res", 64'(v_result), 64'(16'h007F));
    chk("dec_flg", 64'(v_flags), 64'(5'b01000));
    send8(4'd6, 8'h7F, 8'h00);
    chk("inc_res", 64'(v_result), 64'(16'h0080));
    chk("inc_flg", 64'(v_flags), 64'(5'b01010));
    send8(4'd5, 8'h0F, 8'h00);
    chk("not_res", 64'(v_result), 64'(16'h00F0));

    send8(4'd8, 8'hFF, 8'hFF);
    chk("mul_ff_clear", 64'(v_out_valid), 64'(0));
    wait_mul8("mul_ff", 8);
    chk("mul_ff_res", 64'(v_result), 64'(16'hFE01));
    chk("mul_ff_flg", 64'(v_flags), 64'(5'b00010));
    @(posedge clk); #1;
    chk("mul_ff_drain", 64'(v_out_valid), 64'(0));

    // backpressure with a competing op held on the input
    @(negedge clk); v_out_ready = 1'b0;
    send8(4'd4, 8'hF0, 8'h0F);
    chk("xor_res", 64'({v_out_valid, v_result, v_flags}), 64'({1'b1, 16'h00FF, 5'b00010}));
    @(negedge clk);
    v_in_valid = 1'b1; v_op = 4'd0; v_a = 8'h01; v_b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_%0d", i), 64'({v_out_valid, v_in_ready, v_result, v_flags}),
          64'({1'b1, 1'b0, 16'h00FF, 5'b00010}));
    end
    @(negedge clk); v_out_ready = 1'b1;
    @(posedge clk); #1;
    v_in_valid = 1'b0;
    chk("replace_res", 64'({v_out_valid, v_result, v_flags}), 64'({1'b1, 16'h0002, 5'b00000}));
    @(posedge clk); #1;
    chk("replace_drain", 64'(v_out_valid), 64'(0));

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v_in_valid = 1'b1; v_op = bb_op[i]; v_a = bb_a[i]; v_b = bb_b[i];
      @(posedge clk); #1;
      chk($sformatf("b2b_%0d", i), 64'({v_out_valid, v_result, v_flags}),
          64'({1'b1, bb_res[i], bb_flg[i]}));
    end
    v_in_valid = 1'b0;

    send8(4'hD, 8'h55, 8'h33);
    chk("undef", 64'({v_out_valid, v_result, v_flags}), 64'({1'b1, 16'h0000, 5'b00101}));

    // MUL accepted while the previous result drains; operands change mid-flight
    send8(4'd8, 8'h03, 8'h05);
    chk("mul_hs_clear", 64'(v_out_valid), 64'(0));
    v_a = 8'hAA; v_b = 8'h77; v_op = 4'd0;
    wait_mul8("mul_hs", 8);
    chk("mul_hs_res", 64'({v_result, v_flags}), 64'({16'h000F, 5'b00000}));

    @(negedge clk);
    w_in_valid = 1'b1; w_op = 4'd8; w_a = 16'hFFFF; w_b = 16'h0002;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    chk("w16_ready0", 64'(w_in_ready), 64'(0));
    n = 0;
    while (!w_out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w16_latency", 64'(n), 64'(16));
    chk("w16_res", 64'({w_result, w_flags}), 64'({32'h0001FFFE, 5'b00000}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised successor to the team's 8-bit registered ALU. It adds a generic operand width, valid/ready handshakes on input and output, and an iterative shift-add multiplier. Sign is taken from the true result MSB, and an error flag reports undefined opcodes. It sits between the operand-fetch stage and the writeback/flag register of the datapath.

Parameters:
WIDTH, 8, operand width in bits (legal values 4..32); the result is 2*WIDTH bits wide.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  operands and opcode are valid
in_ready  out  1  block can accept an operation this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  4  opcode (see package)
out_valid  out  1  result and flags are valid
out_ready  in  1  consumer accepts the result
result  out  2*WIDTH  result; upper half is zero except for MUL
carry  out  1  carry out (ADD/INC) or borrow (SUB/DEC)
overflow  out  1  signed overflow (ADD/SUB/INC/DEC)
zero  out  1  result == 0
sign  out  1  result MSB (bit 2*WIDTH-1 for MUL, bit WIDTH-1 otherwise)
err  out  1  opcode was undefined

Behaviour:
- Reset (rst low, asynchronous): FSM returns to IDLE; result, carry, overflow, zero, sign, err, out_valid all 0; multiplier state cleared. in_ready = 1 after release.
- Reset mid-MUL aborts the operation; no out_valid is produced.
- Accept: in_valid && in_ready at a rising edge.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 INC A, 7 DEC A, 8 MUL (unsigned), 9 SHL A by b[log2(WIDTH)-1:0], 10 SHR A (logical), 11 SAR A (arithmetic).
- Opcodes 12..15 are undefined: result 0, zero = 1, err = 1.
- Arithmetic:
  - WIDTH+1-bit sum/difference; carry = bit WIDTH.
  - ADD overflow = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
  - SUB overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
  - INC/DEC use b = 1 for the overflow rule.
  - Flags are computed from the new result in the same cycle, never from a stale register.
  - carry and overflow are 0 for logic, shift and MUL ops.
- Single-cycle ops (all except MUL): accepted at edge k; result, flags and out_valid are registered at edge k. State stays IDLE.
- MUL:
  - On accept, FSM goes IDLE -> BUSY; counter = WIDTH; the multiplier sub-module is loaded.
  - One shift-add iteration per cycle.
  - On the edge where the counter reaches 0, result, flags and out_valid are registered and FSM goes BUSY -> IDLE.
  - out_valid rises exactly WIDTH cycles after the accepting edge; in_ready is 0 throughout BUSY.
- Output handshake:
  - out_valid stays high and result/flags are held stable until out_valid && out_ready at an edge.
  - out_valid clears at that edge unless a new op is accepted at the same edge, in which case the new single-cycle result replaces it (back-to-back throughput: 1 op per cycle).
  - A MUL accepted at the same edge clears out_valid, then follows the MUL timing.
- Inputs a, b, op are sampled only at accept; later changes have no effect on an in-flight MUL.

Decomposition:
- Package alu_pkg:
  - op enumerations OP_ADD..OP_SAR and OP_LAST
  - FSM state type {IDLE, BUSY}
  - a function for the signed-overflow rule
- Sub-module alu_mul_seq (WIDTH):
  - load, a, b, busy/done, product[2*WIDTH-1:0]
  - iterative unsigned shift-add, WIDTH cycles
- Top handles decode, combinational single-cycle ops, flags, FSM and the output register.

Test Plan (WIDTH = 8 unless noted):
- Reset: hold rst low mid-MUL (4 cycles after accept), release -> all outputs 0, out_valid never asserts for the aborted MUL, in_ready = 1 on the next cycle.
- ADD 0xFF+0x01 -> result 0x0000, carry 1, zero 1, overflow 0. ADD 0x7F+0x01 -> 0x0080, overflow 1, sign 1, carry 0.
- SUB 0x00-0x01 -> 0x00FF, carry (borrow) 1, sign 1, overflow 0. DEC 0x80 -> 0x007F, overflow 1.
- MUL 0xFF*0xFF -> 0xFE01, sign 1; out_valid exactly 8 cycles after accept; in_ready 0 for those 8 cycles.
- WIDTH = 16: MUL 0xFFFF*0x0002 -> 0x0001FFFE after exactly 16 cycles.
- Backpressure: out_ready low for 5 cycles after an XOR 0xF0^0x0F (0x00FF) -> result/flags stable, in_ready 0.
- Back-to-back: stream AND, OR, SHL 0x81<<1 (0x0002), SAR 0x80>>1 (0x00C0) with out_ready = 1 -> one result per cycle in order.
- Undefined op 0xD -> result 0, zero 1, err 1.
